// File: rtl/stream_seq_pkg.sv
// Shared types and constants for the Xillybus frame sequencer.
// Each 32-bit stream word packs an even sample in LO and an odd sample in HI.
package stream_seq_pkg;

  localparam int FRAME_WORDS_DEF = 512;
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = $clog2(FRAME_WORDS_DEF);

  localparam int SAMPLE_W = 16;
  localparam int LO_LSB   = 0;
  localparam int LO_MSB   = 15;
  localparam int HI_LSB   = 16;
  localparam int HI_MSB   = 31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } seq_state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// One-entry skid register between the result-buffer read port and the host FIFO.
// Handshake: a word moves when valid && ready on the same cycle; in_ready is low while the entry is held.
module stream_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (out_ready) full_d = 1'b0;
    end else if (in_valid && !out_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    if (flush) full_d = 1'b0;
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q || in_valid;
  assign out_data  = full_q ? data_q : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/stream_frame_sequencer.sv
// Gathers a frame from the host FIFO into the core input buffer, starts the core,
// and streams the result buffer back to the host FIFO once the core reports done.
module stream_frame_sequencer
  import stream_seq_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              quiesce,
  input  logic              in_empty,
  output logic              in_rden,
  input  logic [DATA_W-1:0] in_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              core_start,
  input  logic              core_done,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_rd_addr,
  input  logic [DATA_W-1:0] res_rd_data,
  input  logic              out_full,
  output logic              out_wren,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              rd_all_q, rd_all_d;
  logic              pend_q, pend_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic              rd_issue, wr_fire, flush;
  logic              skid_in_valid, skid_in_ready, skid_out_valid, skid_out_ready;
  logic [DATA_W-1:0] skid_out_data;

  // Both phases share one read index (issued reads) and one write index (landed words).
  assign skid_in_valid  = pend_q && (state_q == DRAIN);
  assign skid_out_ready = (state_q == DRAIN) && !out_full && !quiesce;

  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    wr_idx_d      = wr_idx_q;
    rd_all_d      = rd_all_q;
    frame_count_d = frame_count_q;
    in_rden       = 1'b0;
    buf_wr_en     = 1'b0;
    res_rd_en     = 1'b0;
    core_start    = 1'b0;
    out_wren      = 1'b0;
    rd_issue      = 1'b0;
    wr_fire       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!quiesce && !in_empty) state_d = LOAD;
      end
      LOAD: begin
        in_rden   = !quiesce && !in_empty && !rd_all_q;
        buf_wr_en = pend_q;
        rd_issue  = in_rden;
        wr_fire   = buf_wr_en;
        if (buf_wr_en && (wr_idx_q == LAST_IDX)) state_d = START;
      end
      START: begin
        core_start = !quiesce;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) state_d = DRAIN;
      end
      DRAIN: begin
        res_rd_en = !quiesce && !out_full && !rd_all_q && skid_in_ready;
        out_wren  = skid_out_valid && skid_out_ready;
        rd_issue  = res_rd_en;
        wr_fire   = out_wren;
        if (out_wren && (wr_idx_q == LAST_IDX)) begin
          state_d       = IDLE;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_issue) begin
      if (rd_idx_q == LAST_IDX) rd_all_d = 1'b1;
      else                      rd_idx_d = rd_idx_q + 1'b1;
    end
    if (wr_fire) wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;

    if (quiesce) state_d = IDLE;

    // Any phase change or abort restarts the counters and empties the skid entry.
    flush = quiesce || (state_d != state_q);
    if (flush) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      rd_all_d = 1'b0;
    end
    pend_d = rd_issue && !flush;
  end

  stream_skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .clk       (bus_clk),
    .rst_n     (bus_rst_n),
    .flush     (flush),
    .in_valid  (skid_in_valid),
    .in_data   (res_rd_data),
    .in_ready  (skid_in_ready),
    .out_valid (skid_out_valid),
    .out_data  (skid_out_data),
    .out_ready (skid_out_ready)
  );

  assign buf_wr_addr = (state_q == LOAD) ? wr_idx_q : '0;
  assign buf_wr_data = in_data;
  assign res_rd_addr = (state_q == DRAIN) ? rd_idx_q : '0;
  assign out_data    = out_wren ? skid_out_data : '0;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      state_q       <= IDLE;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      rd_all_q      <= 1'b0;
      pend_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_idx_q      <= rd_idx_d;
      wr_idx_q      <= wr_idx_d;
      rd_all_q      <= rd_all_d;
      pend_q        <= pend_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_stream_frame_sequencer.sv
// Bench for stream_frame_sequencer: host FIFO, core and result-buffer models around the DUT,
// with an expected-output queue filled as frames are queued to the host FIFO.
module tb_stream_frame_sequencer;
  import stream_seq_pkg::*;

  localparam int FW = 512;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          bus_clk = 1'b0;
  logic          bus_rst_n = 1'b0;
  logic          quiesce = 1'b0;
  logic          in_empty = 1'b1;
  logic          in_rden;
  logic [DW-1:0] in_data = '0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic          core_start;
  logic          core_done = 1'b0;
  logic          res_rd_en;
  logic [AW-1:0] res_rd_addr;
  logic [DW-1:0] res_rd_data = '0;
  logic          out_full = 1'b0;
  logic          out_wren;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [15:0]   frame_count;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] in_mem [FW];
  logic [DW-1:0] res_mem [FW];
  logic [AW-1:0] exp_wr_addr = '0;
  logic [AW-1:0] rd_res_addr_s = '0;

  int wr_seen = 0, out_seen = 0, starts = 0, cyc = 0, done_timer = 0;
  int stray_req_n = 0, stray_ack_n = 0;
  bit gap_mode = 0, bp_mode = 0, prev_start = 0, rd_in_s = 0, rd_res_s = 0;

  stream_frame_sequencer dut (
    .bus_clk     (bus_clk),
    .bus_rst_n   (bus_rst_n),
    .quiesce     (quiesce),
    .in_empty    (in_empty),
    .in_rden     (in_rden),
    .in_data     (in_data),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .core_start  (core_start),
    .core_done   (core_done),
    .res_rd_en   (res_rd_en),
    .res_rd_addr (res_rd_addr),
    .res_rd_data (res_rd_data),
    .out_full    (out_full),
    .out_wren    (out_wren),
    .out_data    (out_data),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  // Observe this cycle's strobes midway between edges.
  always @(negedge bus_clk) begin
    rd_in_s       = in_rden;
    rd_res_s      = res_rd_en;
    rd_res_addr_s = res_rd_addr;
    if (in_rden) check("rden_while_empty", 32'(in_empty), 32'd0);
    if (buf_wr_en) begin
      check("wr_addr_order", 32'(buf_wr_addr), 32'(exp_wr_addr));
      in_mem[buf_wr_addr] = buf_wr_data;
      exp_wr_addr = exp_wr_addr + 1'b1;
      wr_seen++;
    end
    if (core_start) begin
      check("start_single_pulse", 32'(prev_start), 32'd0);
      res_mem = in_mem;
      done_timer = 100;
      starts++;
    end
    prev_start = core_start;
    if (out_wren) begin
      out_seen++;
      if (exp_q.size() == 0) check("out_unexpected_wren", 32'(out_wren), 32'd0);
      else check("out_data", out_data, exp_q.pop_front());
    end
    if (quiesce || !bus_rst_n) exp_wr_addr = '0;
    if (!bus_rst_n) exp_q.delete();
  end

  // Host FIFO, result buffer and core models update just after the active edge.
  always @(posedge bus_clk) begin
    #1;
    cyc++;
    if (rd_in_s && host_q.size() > 0) in_data = host_q.pop_front();
    else in_data = $urandom;
    if (rd_res_s) res_rd_data = res_mem[rd_res_addr_s];
    else res_rd_data = $urandom;
    core_done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) core_done = 1'b1;
    end
    if (stray_req_n != stray_ack_n) begin
      core_done = 1'b1;
      stray_ack_n = stray_req_n;
    end
    in_empty = (host_q.size() == 0) || (gap_mode && ((cyc % 6) < 3));
    out_full = bp_mode && ((cyc % 7) < 5);
  end

  task automatic push_frame(input bit nominal, input bit want_out, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      if (nominal) begin
        w[LO_MSB:LO_LSB] = 16'(2 * i);
        w[HI_MSB:HI_LSB] = 16'(2 * i + 1);
      end else begin
        w = $urandom;
      end
      host_q.push_back(w);
      if (want_out) exp_q.push_back(w);
    end
  endtask

  task automatic wait_fc(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (frame_count !== 16'(target) && n < budget) begin
      @(negedge bus_clk);
      n++;
    end
    check(tag, 32'(frame_count), 32'(target));
    step(1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},        32'(busy),        32'd0);
    check({pfx, "_frame_count"}, 32'(frame_count), 32'd0);
    check({pfx, "_in_rden"},     32'(in_rden),     32'd0);
    check({pfx, "_buf_wr_en"},   32'(buf_wr_en),   32'd0);
    check({pfx, "_buf_wr_addr"}, 32'(buf_wr_addr), 32'd0);
    check({pfx, "_core_start"},  32'(core_start),  32'd0);
    check({pfx, "_res_rd_en"},   32'(res_rd_en),   32'd0);
    check({pfx, "_res_rd_addr"}, 32'(res_rd_addr), 32'd0);
    check({pfx, "_out_wren"},    32'(out_wren),    32'd0);
    check({pfx, "_out_data"},    out_data,         32'd0);
  endtask

  initial begin
    int n;
    int base_wr, base_out, base_st;

    step(3);
    @(negedge bus_clk);
    check_reset_outputs("reset");
    step(1);
    bus_rst_n = 1'b1;
    step(2);

    // Nominal frame with the counting sample pattern.
    push_frame(1'b1, 1'b1, FW);
    wait_fc(1, 4000, "nominal_frame_count");
    @(negedge bus_clk);
    check("nominal_busy_after", 32'(busy), 32'd0);
    check("nominal_starts", 32'(starts), 32'd1);
    check("nominal_drained", 32'(exp_q.size()), 32'd0);
    step(1);

    // Host FIFO empty toggling every 3 cycles.
    gap_mode = 1;
    base_wr = wr_seen;
    push_frame(1'b0, 1'b1, FW);
    wait_fc(2, 5000, "gaps_frame_count");
    gap_mode = 0;
    check("gaps_writes", 32'(wr_seen - base_wr), 32'(FW));
    check("gaps_starts", 32'(starts), 32'd2);
    check("gaps_drained", 32'(exp_q.size()), 32'd0);

    // Output FIFO full 5 of every 7 cycles.
    bp_mode = 1;
    base_out = out_seen;
    push_frame(1'b0, 1'b1, FW);
    wait_fc(3, 9000, "bp_frame_count");
    bp_mode = 0;
    check("bp_out_count", 32'(out_seen - base_out), 32'(FW));
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Quiesce after 200 loaded words, then a fresh frame.
    base_wr = wr_seen;
    base_st = starts;
    push_frame(1'b0, 1'b0, 256);
    n = 0;
    while ((wr_seen - base_wr) < 200 && n < 2000) begin
      @(negedge bus_clk);
      n++;
    end
    check("q_reached_200", 32'((wr_seen - base_wr) >= 200), 32'd1);
    step(1);
    quiesce = 1'b1;
    step(1);
    @(negedge bus_clk);
    check("q_busy_dropped", 32'(busy), 32'd0);
    check("q_frame_count_kept", 32'(frame_count), 32'd3);
    step(3);
    host_q.delete();
    step(2);
    quiesce = 1'b0;
    step(5);
    check("q_no_start", 32'(starts), 32'(base_st));
    check("q_still_idle", 32'(busy), 32'd0);
    push_frame(1'b0, 1'b1, FW);
    wait_fc(4, 4000, "q_frame_count");
    check("q_one_start", 32'(starts), 32'(base_st + 1));
    check("q_drained", 32'(exp_q.size()), 32'd0);

    // Reset pulse while draining, around output word 300.
    base_out = out_seen;
    push_frame(1'b0, 1'b1, FW);
    n = 0;
    while ((out_seen - base_out) < 300 && n < 4000) begin
      @(negedge bus_clk);
      n++;
    end
    check("rst_reached_300", 32'((out_seen - base_out) >= 300), 32'd1);
    step(1);
    bus_rst_n = 1'b0;
    step(1);
    bus_rst_n = 1'b1;
    @(negedge bus_clk);
    check_reset_outputs("after_rst");
    step(1);
    base_out = out_seen;
    step(60);
    check("rst_no_wren", 32'(out_seen - base_out), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    // Three frames queued back to back, stray core_done during two loads.
    base_st = starts;
    base_out = out_seen;
    push_frame(1'b0, 1'b1, FW);
    push_frame(1'b0, 1'b1, FW);
    push_frame(1'b0, 1'b1, FW);
    step(30);
    check("b2b_busy_in_load", 32'(busy), 32'd1);
    stray_req_n++;
    wait_fc(1, 4000, "b2b_first_frame");
    step(30);
    stray_req_n++;
    wait_fc(3, 8000, "b2b_frame_count");
    @(negedge bus_clk);
    check("b2b_busy_after", 32'(busy), 32'd0);
    check("b2b_starts", 32'(starts), 32'(base_st + 3));
    check("b2b_out_count", 32'(out_seen - base_out), 32'(3 * FW));
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
